// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file / scoreboard slice.
// REGISTER_WIDTH : default architectural register width in bits
// REGISTER_DEPTH : default number of architectural registers
package regfile_scoreboard_pkg;

  localparam int REGISTER_WIDTH = 32;
  localparam int REGISTER_DEPTH = 32;

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_scoreboard_popcount_tree.sv
// Combinational population count of the pending-bit vector.
// Ports:
//   vec_i : input  [WIDTH-1:0] bit vector to count
//   cnt_o : output [CNT_W-1:0] number of ones in vec_i
module popcount_tree
  import regfile_scoreboard_pkg::*;
#(
  parameter int WIDTH = REGISTER_DEPTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Accumulate ones; the result width holds WIDTH so it cannot overflow.
  always_comb begin
    cnt_o = {CNT_W{1'b0}};
    for (int k = 0; k < WIDTH; k++) begin
      cnt_o = cnt_o + CNT_W'(vec_i[k]);
    end
  end

endmodule : popcount_tree

// File: rtl/regfile_scoreboard.sv
// Architectural register file with a pending-producer scoreboard.
// Ports:
//   clk           : clock, all state updates on the rising edge
//   rst           : synchronous active-low reset
//   rd_en         : [NUM_READ] per-port read request
//   rd_addr       : [NUM_READ*ADDR_W] packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data       : [NUM_READ*DATA_WIDTH] registered read results, same packing
//   hazard        : some enabled read targets a register still awaiting its producer
//   issue_valid/issue_addr : destination of a newly issued instruction
//   wr_valid/wr_addr/wr_data : writeback
//   flush         : squash all in-flight producers
//   pending_count : registered number of pending registers
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH = REGISTER_WIDTH,
  parameter int DEPTH      = REGISTER_DEPTH,
  parameter int NUM_READ   = 2,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ-1:0]            rd_en,
  input  logic [NUM_READ*ADDR_W-1:0]     rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic                           hazard,
  input  logic                           issue_valid,
  input  logic [ADDR_W-1:0]              issue_addr,
  input  logic                           wr_valid,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           flush,
  output logic [CNT_W-1:0]               pending_count
);

  // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [NUM_READ-1:0]   haz_s;
  logic                  wr_ok_s;
  logic                  iss_ok_s;

  // Register 0 is hardwired: never written, never pending.
  assign wr_ok_s  = wr_valid && (wr_addr != {ADDR_W{1'b0}}) && in_range(wr_addr);
  assign iss_ok_s = issue_valid && !flush && (issue_addr != {ADDR_W{1'b0}}) && in_range(issue_addr);

  // Next pending vector: flush clears all; a same-cycle issue beats the writeback clear.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      pend_d[k] = flush                                      ? 1'b0 :
                  (iss_ok_s && (issue_addr == ADDR_W'(k)))   ? 1'b1 :
                  (wr_ok_s && (wr_addr == ADDR_W'(k)))       ? 1'b0 :
                                                               pend_q[k];
    end
  end

  // Count the next-state vector so the registered count tracks pend_q exactly.
  popcount_tree #(
    .WIDTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_popcount_tree (
    .vec_i (pend_d),
    .cnt_o (cnt_d)
  );

  // Register array and scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= {DATA_WIDTH{1'b0}};
      end
      pend_q <= {DEPTH{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      if (wr_ok_s) begin
        regs_q[wr_addr] <= wr_data;
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_W-1:0]     ra_s;
    logic                  byp_s;
    logic [DATA_WIDTH-1:0] val_s;
    logic [DATA_WIDTH-1:0] rd_q;

    assign ra_s  = rd_addr[g*ADDR_W +: ADDR_W];
    assign byp_s = wr_valid && (wr_addr == ra_s);
    assign val_s = ((ra_s == {ADDR_W{1'b0}}) || !in_range(ra_s)) ? {DATA_WIDTH{1'b0}} :
                   byp_s                                         ? wr_data :
                                                                   regs_q[ra_s];
    // A register being written back this cycle is no longer a hazard: its data is bypassed.
    assign haz_s[g] = rd_en[g] && in_range(ra_s) && pend_q[ra_s] && !byp_s;

    // Read port register; holds its value while the port is idle.
    always_ff @(posedge clk) begin
      if (!rst) begin
        rd_q <= {DATA_WIDTH{1'b0}};
      end else if (rd_en[g]) begin
        rd_q <= val_s;
      end else begin
        rd_q <= rd_q;
      end
    end

    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  assign hazard        = |haz_s;
  assign pending_count = cnt_q;

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        hazard;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flush;
  logic [5:0]  pending_count;

  int errors = 0;
  int checks = 0;

  // reference model for the pseudo-random phase
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  logic [31:0] m_rd   [2];

  regfile_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .hazard        (hazard),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .flush         (flush),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en       = 2'b00;
    rd_addr     = 10'd0;
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
    wr_valid    = 1'b0;
    wr_addr     = 5'd0;
    wr_data     = 32'd0;
    flush       = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] a);
    idle();
    issue_valid = 1'b1;
    issue_addr  = a;
    tick();
  endtask

  initial begin
    logic [4:0]  ra [2];
    logic        exp_haz;
    logic [5:0]  exp_cnt;

    rst = 1'b0;
    idle();
    // reset state
    tick();
    tick();
    chk("reset_rd_data", {32'd0, rd_data}, 64'd0);
    chk("reset_count", {58'd0, pending_count}, 64'd0);
    chk("reset_hazard", {63'd0, hazard}, 64'd0);
    rst = 1'b1;
    chk("hazard_after_release", {63'd0, hazard}, 64'd0);

    // write r5 then read it
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    chk("read_r5_p0", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    // write and read r5 in the same cycle on port 1
    idle();
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D;
    rd_en = 2'b10; rd_addr = {5'd5, 5'd0};
    tick();
    chk("bypass_r5_p1", {32'd0, rd_data[63:32]}, 64'hCAFEF00D);
    chk("hold_p0", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);

    // register 0
    idle();
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    tick();
    chk("read_r0", {32'd0, rd_data[31:0]}, 64'd0);
    do_issue(5'd0);
    idle();
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    #1;
    chk("r0_hazard", {63'd0, hazard}, 64'd0);
    chk("r0_count", {58'd0, pending_count}, 64'd0);

    // issue r3, read hazard, then writeback with bypass
    do_issue(5'd3);
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    #1;
    chk("r3_hazard", {63'd0, hazard}, 64'd1);
    chk("r3_count", {58'd0, pending_count}, 64'd1);
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    #1;
    chk("r3_wb_hazard", {63'd0, hazard}, 64'd0);
    tick();
    chk("r3_wb_bypass", {32'd0, rd_data[31:0]}, 64'h33);
    chk("r3_wb_count", {58'd0, pending_count}, 64'd0);

    // issue and writeback r7 together
    idle();
    issue_valid = 1'b1; issue_addr = 5'd7;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    tick();
    chk("r7_count", {58'd0, pending_count}, 64'd1);
    idle();
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    #1;
    chk("r7_hazard", {63'd0, hazard}, 64'd1);
    tick();
    chk("r7_data", {32'd0, rd_data[63:32]}, 64'h77);
    do_issue(5'd7);
    chk("r7_reissue_count", {58'd0, pending_count}, 64'd1);

    // fill, then flush with a dropped issue and a surviving write
    do_issue(5'd1);
    do_issue(5'd2);
    do_issue(5'd3);
    do_issue(5'd4);
    chk("fill_count", {58'd0, pending_count}, 64'd5);
    idle();
    flush = 1'b1;
    issue_valid = 1'b1; issue_addr = 5'd9;
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 32'hA;
    tick();
    chk("flush_count", {58'd0, pending_count}, 64'd0);
    idle();
    rd_en = 2'b11; rd_addr = {5'd10, 5'd9};
    #1;
    chk("flush_r9_hazard", {63'd0, hazard}, 64'd0);
    tick();
    chk("flush_r10_data", {32'd0, rd_data[63:32]}, 64'hA);

    // hazard gated by rd_en on port 1
    do_issue(5'd12);
    idle();
    rd_en = 2'b10; rd_addr = {5'd12, 5'd12};
    #1;
    chk("p1_hazard", {63'd0, hazard}, 64'd1);
    rd_en = 2'b00;
    #1;
    chk("p1_disabled_hazard", {63'd0, hazard}, 64'd0);

    // reset in the middle of activity
    idle();
    rst = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd6;
    wr_valid = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
    rd_en = 2'b11; rd_addr = {5'd10, 5'd10};
    tick();
    chk("midrst_count", {58'd0, pending_count}, 64'd0);
    chk("midrst_rd", rd_data, 64'd0);
    rst = 1'b1;
    idle();
    rd_en = 2'b11; rd_addr = {5'd6, 5'd5};
    #1;
    chk("midrst_hazard", {63'd0, hazard}, 64'd0);
    tick();
    chk("midrst_regs", rd_data, 64'd0);

    // pseudo-random stream against a small model (state is all zero here)
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    m_pend = 32'd0;
    m_rd[0] = 32'd0;
    m_rd[1] = 32'd0;
    for (int n = 0; n < 500; n++) begin
      idle();
      rd_en       = 2'($urandom_range(0, 3));
      ra[0]       = 5'($urandom_range(0, 7));
      ra[1]       = 5'($urandom_range(0, 7));
      rd_addr     = {ra[1], ra[0]};
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_addr  = 5'($urandom_range(0, 7));
      wr_valid    = ($urandom_range(0, 2) == 0);
      wr_addr     = 5'($urandom_range(0, 7));
      wr_data     = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      exp_haz = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p] && m_pend[ra[p]] && !(wr_valid && wr_addr == ra[p])) exp_haz = 1'b1;
        if (rd_en[p]) begin
          if (ra[p] == 5'd0) m_rd[p] = 32'd0;
          else if (wr_valid && wr_addr == ra[p]) m_rd[p] = wr_data;
          else m_rd[p] = m_regs[ra[p]];
        end
      end
      if (flush) m_pend = 32'd0;
      else begin
        if (wr_valid && wr_addr != 5'd0) m_pend[wr_addr] = 1'b0;
        if (issue_valid && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
      end
      if (wr_valid && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
      exp_cnt = 6'd0;
      for (int k = 0; k < 32; k++) exp_cnt = exp_cnt + 6'(m_pend[k]);
      #1;
      chk("rand_hazard", {63'd0, hazard}, {63'd0, exp_haz});
      tick();
      chk("rand_count", {58'd0, pending_count}, {58'd0, exp_cnt});
      chk("rand_rd", rd_data, {m_rd[1], m_rd[0]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_scoreboard
